arb_mux_reg: RTL and testbench
==============================

Name: arb_mux_reg

Overview:
- Parametrised successor to the datapath 2:1 16-bit select mux: NUM_IN producer channels of WIDTH bits, each with valid/ready.
- Arbitrates among channels and registers the winner into a single output stage with valid/ready.
- Used where several datapath sources share one sink, e.g. PC/ALU/memory results into the register-file write port, or fetch/data into a shared memory port.
- Arbitration is fixed-priority or round-robin, chosen by parameter.

Parameters:
- WIDTH, 16, data width per channel.
- NUM_IN, 2, number of input channels (>=1).
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W (localparam, not overridable) = max(1, clog2(NUM_IN)).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel request.
- in_ready  output  NUM_IN  per-channel accept; transfer on channel i when in_valid[i] && in_ready[i].
- out_data  output  WIDTH  registered winner data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  sink accepts; transfer when out_valid && out_ready.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, RR pointer=0.
  - in_ready is all zeros while reset_n is low.
  - A pending output word is discarded.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is 1.
- Grant (combinational, one-hot or zero):
  - Fixed priority: lowest index i with in_valid[i].
  - Round-robin: first valid index scanning from ptr upward, wrapping modulo NUM_IN.
- in_ready[i] = load_en && grant[i] && reset_n. At most one in_ready bit is high per cycle.
- in_ready may depend combinationally on in_valid. Producers must not make in_valid depend on in_ready.
- On an input transfer from channel g: out_data <= channel g data, out_src <= g, out_valid <= 1.
- Latency: input transfer at edge N gives out_valid=1 after edge N. Throughput is one word per cycle when out_ready is held high.
- If out_valid && out_ready and no channel is valid, out_valid <= 0. out_data and out_src keep their last values.
- Stall: while out_valid && !out_ready, out_data, out_src and out_valid are held stable and all in_ready are 0.
- RR pointer: after a transfer from g, ptr <= (g+1) mod NUM_IN, including the wrap from NUM_IN-1 to 0. Without a transfer, ptr is unchanged. ptr is unused in fixed mode.
- NUM_IN=1: grant[0]=in_valid[0] and out_src is constant 0. The block degenerates to a one-stage pipeline register.
- Non-power-of-two NUM_IN: ptr never exceeds NUM_IN-1.

Optional Feature:
- Macro: ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_lock, NUM_IN bits.
  - A transfer from g with in_lock[g]=1 sets lock_active=1 and lock_id=g.
  - While lock_active, grant is forced to lock_id; other channels see in_ready=0 even if lock_id is not valid.
  - A transfer from lock_id with in_lock=0 clears the lock.
  - The RR pointer advances only when the lock clears.
  - Reset clears lock_active.
- Undefined: no in_lock port and no lock state; arbitration is exactly as above.

Decomposition:
- Shared package arb_mux_pkg:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - clog2 helper function, shared by other parametrised datapath blocks.
- One sub-module, arb_mux_grant: combinational grant generator with inputs in_valid, ptr, mode (and lock state) and output one-hot grant.
- Output register and pointer stay in arb_mux_reg.

Test Plan:
- Reset mid-stream: out_valid=1 with data 0x1234, assert reset_n=0 between edges -> out_valid=0, out_data=0 immediately, in_ready=0 until release.
- Fixed priority, NUM_IN=4, all valid, out_ready=1 -> ch0 wins every cycle; out_src=0 and in_ready=4'b0001 continuously.
- Round-robin, NUM_IN=3, all valid, out_ready=1 -> out_src sequence 0,1,2,0,1 on consecutive cycles, one word per cycle.
- Backpressure: out_ready=0 for 5 cycles with out_data=0xBEEF -> out_data/out_src/out_valid stable, in_ready=0.
- Backpressure release: raise out_ready -> next word loads on the same edge as the drain, no bubble.
- Drain to empty: single transfer on ch1 (0x00AA), then no valids, out_ready=1 -> out_valid high exactly one cycle, out_src=1, then 0.
- ARB_MUX_LOCK_EN, RR, ch2 sends 3 words with in_lock=1,1,0 while ch0 is valid -> out_src 2,2,2, then 0; ch0 in_ready=0 throughout the lock.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated output-register mux family.
//
// Contents:
//   ARB_FIXED / ARB_RR : arbitration mode encodings for the ARB_MODE parameter.
//   clog2()            : ceiling log2, usable in parameter expressions.
package arb_mux_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Ceiling log2; clog2(0) and clog2(1) return 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_grant.sv
// Combinational grant generator for arb_mux_reg.
//
// Ports:
//   in_valid    : per-channel request.
//   ptr         : round-robin start index (ignored when mode is 0).
//   mode        : 0 = fixed priority from index 0, 1 = round-robin from ptr.
//   lock_active : (ARB_MUX_LOCK_EN only) a channel holds the output.
//   lock_id     : (ARB_MUX_LOCK_EN only) index of the locking channel.
//   grant       : one-hot winner, or all zeros when nothing may win.
//
// Optional feature macro: ARB_MUX_LOCK_EN.
module arb_mux_grant #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned SEL_W  = 1
) (
    input  logic [NUM_IN-1:0] in_valid,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
`ifdef ARB_MUX_LOCK_EN
    input  logic              lock_active,
    input  logic [SEL_W-1:0]  lock_id,
`endif
    output logic [NUM_IN-1:0] grant
);

    int   base;
    logic found;

    // Scan [base, NUM_IN) first, then [0, base): the wrap-around search order.
    always_comb begin
        grant = '0;
        found = 1'b0;
        base  = mode ? int'(ptr) : 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && (i >= base) && in_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && (i < base) && in_valid[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
`ifdef ARB_MUX_LOCK_EN
        // A held lock overrides arbitration; nobody else may win even if the
        // lock owner is momentarily idle.
        if (lock_active) begin
            grant = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (SEL_W'(i) == lock_id) begin
                    grant[i] = in_valid[i];
                end
            end
        end
`endif
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel valid/ready arbiter feeding a single registered output stage.
//
// Parameters:
//   WIDTH    : data width per channel.
//   NUM_IN   : number of producer channels (>= 1).
//   ARB_MODE : ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
//
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset.
//   in_data        : channel i at bits [i*WIDTH +: WIDTH].
//   in_valid       : per-channel request.
//   in_ready       : per-channel accept (at most one bit high).
//   in_lock        : (ARB_MUX_LOCK_EN only) keep the grant after this transfer.
//   out_data       : registered winner data.
//   out_valid      : out_data holds an untaken word.
//   out_ready      : sink accepts.
//   out_src        : channel index that produced out_data.
//
// Optional feature macro: ARB_MUX_LOCK_EN.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 16,
    parameter  int unsigned NUM_IN   = 2,
    parameter  int unsigned ARB_MODE = ARB_FIXED,
    localparam int unsigned SEL_W    = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_lock,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  out_src_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_d;
    logic [NUM_IN-1:0] grant;
    logic              load_en;
    logic              xfer;
    logic [SEL_W-1:0]  win;
    logic [WIDTH-1:0]  win_data;
    logic              advance;

`ifdef ARB_MUX_LOCK_EN
    logic             lock_active_q;
    logic [SEL_W-1:0] lock_id_q;
    logic             win_lock;
`endif

    arb_mux_grant #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_grant (
        .in_valid    (in_valid),
        .ptr         (ptr_q),
        .mode        (ARB_MODE == ARB_RR),
`ifdef ARB_MUX_LOCK_EN
        .lock_active (lock_active_q),
        .lock_id     (lock_id_q),
`endif
        .grant       (grant)
    );

    assign load_en  = !out_valid_q || out_ready;
    // reset_n gates in_ready so no producer sees an accept while held in reset.
    assign in_ready = (load_en && reset_n) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    // grant is one-hot, so OR-ing the selected fields yields the winner.
    always_comb begin
        win      = '0;
        win_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                win      = win | SEL_W'(i);
                win_data = win_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    assign win_lock = |(in_lock & grant);
    // The pointer only moves once a channel releases (or never takes) the lock.
    assign advance  = xfer && !win_lock;
`else
    assign advance  = xfer;
`endif

    assign ptr_d = (win == SEL_W'(NUM_IN - 1)) ? '0 : win + SEL_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            if (xfer) begin
                out_data_q  <= win_data;
                out_src_q   <= win;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (advance) begin
                ptr_q <= ptr_d;
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_active_q <= 1'b0;
            lock_id_q     <= '0;
        end else if (xfer) begin
            lock_active_q <= win_lock;
            if (win_lock) begin
                lock_id_q <= win;
            end
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed testbench for arb_mux_reg: a 4-channel fixed-priority instance and
// a 3-channel round-robin instance share clock and reset. The lock scenario is
// compiled in only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux_reg;
    import arb_mux_pkg::*;

    logic clock;
    logic reset_n;

    // Fixed-priority DUT, 4 channels.
    logic [63:0] fx_data;
    logic [3:0]  fx_valid;
    logic [3:0]  fx_ready;
    logic [15:0] fx_out_data;
    logic        fx_out_valid;
    logic        fx_out_ready;
    logic [1:0]  fx_out_src;

    // Round-robin DUT, 3 channels.
    logic [47:0] rr_data;
    logic [2:0]  rr_valid;
    logic [2:0]  rr_ready;
    logic [15:0] rr_out_data;
    logic        rr_out_valid;
    logic        rr_out_ready;
    logic [1:0]  rr_out_src;

`ifdef ARB_MUX_LOCK_EN
    logic [3:0] fx_lock;
    logic [2:0] rr_lock;
`endif

    int n_cmp;
    int n_err;

    arb_mux_reg #(
        .WIDTH    (16),
        .NUM_IN   (4),
        .ARB_MODE (ARB_FIXED)
    ) u_fix (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (fx_data),
        .in_valid  (fx_valid),
        .in_ready  (fx_ready),
`ifdef ARB_MUX_LOCK_EN
        .in_lock   (fx_lock),
`endif
        .out_data  (fx_out_data),
        .out_valid (fx_out_valid),
        .out_ready (fx_out_ready),
        .out_src   (fx_out_src)
    );

    arb_mux_reg #(
        .WIDTH    (16),
        .NUM_IN   (3),
        .ARB_MODE (ARB_RR)
    ) u_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (rr_data),
        .in_valid  (rr_valid),
        .in_ready  (rr_ready),
`ifdef ARB_MUX_LOCK_EN
        .in_lock   (rr_lock),
`endif
        .out_data  (rr_out_data),
        .out_valid (rr_out_valid),
        .out_ready (rr_out_ready),
        .out_src   (rr_out_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] exp_src [5];
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        n_cmp = 0;
        n_err = 0;
        reset_n      = 1'b1;
        fx_data      = '0;
        fx_valid     = '0;
        fx_out_ready = 1'b0;
        rr_data      = '0;
        rr_valid     = '0;
        rr_out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
        fx_lock = '0;
        rr_lock = '0;
`endif
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, fx_out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, fx_out_data}, 32'd0);
        check_eq("rst_out_src", {30'd0, fx_out_src}, 32'd0);
        tick();
        tick();
        #2 reset_n = 1'b1;

        // Reset mid-stream: load 0x1234, then pull reset between edges.
        fx_valid         = 4'b0001;
        fx_data[15:0]    = 16'h1234;
        tick();
        check_eq("pre_rst_valid", {31'd0, fx_out_valid}, 32'd1);
        check_eq("pre_rst_data", {16'd0, fx_out_data}, 32'h1234);
        fx_valid = 4'b1111;
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, fx_out_valid}, 32'd0);
        check_eq("mid_rst_data", {16'd0, fx_out_data}, 32'd0);
        check_eq("mid_rst_ready", {28'd0, fx_ready}, 32'd0);
        tick();
        check_eq("rst_held_ready", {28'd0, fx_ready}, 32'd0);
        check_eq("rst_held_valid", {31'd0, fx_out_valid}, 32'd0);
        #2 reset_n = 1'b1;
        #1;
        check_eq("post_rst_ready", {28'd0, fx_ready}, 32'h1);

        // Fixed priority: all valid, sink always ready, ch0 wins every cycle.
        fx_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fx_data = {16'h3333, 16'h2222, 16'h1111, 16'(16'hA000 + k)};
            #1;
            check_eq($sformatf("fix_ready_%0d", k), {28'd0, fx_ready}, 32'h1);
            tick();
            check_eq($sformatf("fix_src_%0d", k), {30'd0, fx_out_src}, 32'd0);
            check_eq($sformatf("fix_data_%0d", k), {16'd0, fx_out_data}, 32'hA000 + k);
        end

        // Backpressure: hold 0xBEEF while the sink stalls.
        fx_valid      = 4'b0001;
        fx_data[15:0] = 16'hBEEF;
        tick();
        check_eq("bp_load", {16'd0, fx_out_data}, 32'hBEEF);
        fx_out_ready = 1'b0;
        fx_valid     = 4'b1111;
        fx_data      = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("bp_ready_%0d", k), {28'd0, fx_ready}, 32'd0);
            tick();
            check_eq($sformatf("bp_data_%0d", k), {16'd0, fx_out_data}, 32'hBEEF);
            check_eq($sformatf("bp_valid_%0d", k), {31'd0, fx_out_valid}, 32'd1);
            check_eq($sformatf("bp_src_%0d", k), {30'd0, fx_out_src}, 32'd0);
        end

        // Release: the next word loads on the draining edge.
        fx_out_ready = 1'b1;
        fx_valid     = 4'b0100;
        #1;
        check_eq("rel_ready", {28'd0, fx_ready}, 32'h4);
        tick();
        check_eq("rel_data", {16'd0, fx_out_data}, 32'h3333);
        check_eq("rel_src", {30'd0, fx_out_src}, 32'd2);
        check_eq("rel_valid", {31'd0, fx_out_valid}, 32'd1);

        // Drain to empty after a single ch1 word.
        fx_valid       = 4'b0010;
        fx_data[31:16] = 16'h00AA;
        tick();
        check_eq("drain_valid1", {31'd0, fx_out_valid}, 32'd1);
        check_eq("drain_src1", {30'd0, fx_out_src}, 32'd1);
        check_eq("drain_data1", {16'd0, fx_out_data}, 32'h00AA);
        fx_valid = 4'b0000;
        tick();
        check_eq("drain_valid0", {31'd0, fx_out_valid}, 32'd0);
        check_eq("drain_src_hold", {30'd0, fx_out_src}, 32'd1);
        check_eq("drain_data_hold", {16'd0, fx_out_data}, 32'h00AA);

        // Round-robin, 3 channels all valid.
        rr_out_ready = 1'b1;
        rr_valid     = 3'b111;
        rr_data      = {16'h0C02, 16'h0C01, 16'h0C00};
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("rr_ready_%0d", k), {29'd0, rr_ready}, 32'd1 << exp_src[k]);
            tick();
            check_eq($sformatf("rr_src_%0d", k), {30'd0, rr_out_src}, {30'd0, exp_src[k]});
            check_eq($sformatf("rr_data_%0d", k), {16'd0, rr_out_data},
                     32'h0C00 + {30'd0, exp_src[k]});
            check_eq($sformatf("rr_valid_%0d", k), {31'd0, rr_out_valid}, 32'd1);
        end
        rr_valid = 3'b000;
        tick();
        check_eq("rr_empty", {31'd0, rr_out_valid}, 32'd0);

`ifdef ARB_MUX_LOCK_EN
        // Pointer now sits at 2: ch2 wins and locks out ch0 for three words.
        rr_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            rr_lock = (k < 2) ? 3'b100 : 3'b000;
            rr_data = {16'(16'h0D00 + k), 16'h0000, 16'h0E00};
            #1;
            check_eq($sformatf("lock_ready_%0d", k), {29'd0, rr_ready}, 32'h4);
            tick();
            check_eq($sformatf("lock_src_%0d", k), {30'd0, rr_out_src}, 32'd2);
            check_eq($sformatf("lock_data_%0d", k), {16'd0, rr_out_data}, 32'h0D00 + k);
        end
        rr_valid = 3'b001;
        rr_lock  = 3'b000;
        #1;
        check_eq("unlock_ready", {29'd0, rr_ready}, 32'h1);
        tick();
        check_eq("unlock_src", {30'd0, rr_out_src}, 32'd0);
        check_eq("unlock_data", {16'd0, rr_out_data}, 32'h0E00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
